// File: rtl/shiftreg_tap.sv
// Tapped shift register: DEPTH stages, output tap chosen by sel (sel=0 bypasses d); optional rotate with SHIFTREG_TAP_ROTATE_EN.
// Latency: sel=k gives the word shifted in k enabled clocks ago; q/valid are combinational from sel and state.
// Backpressure: none; en gates shifting, flush/reset clear stages and fill count.
module shiftreg_tap #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    localparam int SELW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
`ifdef SHIFTREG_TAP_ROTATE_EN
    input  logic             rot,
`endif
    input  logic [WIDTH-1:0] d,
    input  logic [SELW-1:0]  sel,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic [SELW-1:0]  fill_cnt
);

    localparam logic [SELW-1:0] DEPTH_S = SELW'(DEPTH);

    logic [WIDTH-1:0] stage_q [1:DEPTH];
    logic [WIDTH-1:0] stage_d [1:DEPTH];
    logic [SELW-1:0]  fill_cnt_q;
    logic [SELW-1:0]  fill_cnt_d;
    logic             rot_act;

`ifdef SHIFTREG_TAP_ROTATE_EN
    assign rot_act = rot;
`else
    assign rot_act = 1'b0;
`endif

    always_comb begin
        stage_d    = stage_q;
        fill_cnt_d = fill_cnt_q;
        if (flush) begin
            for (int k = 1; k <= DEPTH; k++) begin
                stage_d[k] = '0;
            end
            fill_cnt_d = '0;
        end else if (en) begin
            // Rotation recirculates the last stage and does not count as a new word.
            stage_d[1] = rot_act ? stage_q[DEPTH] : d;
            for (int k = 2; k <= DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
            end
            if (!rot_act && (fill_cnt_q != DEPTH_S)) begin
                fill_cnt_d = fill_cnt_q + SELW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= DEPTH; k++) begin
                stage_q[k] <= '0;
            end
            fill_cnt_q <= '0;
        end else begin
            stage_q    <= stage_d;
            fill_cnt_q <= fill_cnt_d;
        end
    end

    always_comb begin
        q     = '0;
        valid = 1'b0;
        if (sel == '0) begin
            q     = d;
            valid = 1'b1;
        end else begin
            for (int k = 1; k <= DEPTH; k++) begin
                if (sel == SELW'(k)) begin
                    q = stage_q[k];
                end
            end
            valid = (sel <= DEPTH_S) && (fill_cnt_q >= sel);
        end
    end

    assign fill_cnt = fill_cnt_q;

endmodule

// File: tb/tb_shiftreg_tap.sv
// Directed bench for shiftreg_tap: vector table on an 8x3 instance plus hand sequences on a 16x5 instance.
module tb_shiftreg_tap;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WIDTH=8, DEPTH=3
    logic        reset, en, flush;
    logic [7:0]  d;
    logic [1:0]  sel;
    logic [7:0]  q;
    logic        valid;
    logic [1:0]  fill_cnt;
`ifdef SHIFTREG_TAP_ROTATE_EN
    logic        rot;
`endif

    // Instance B: WIDTH=16, DEPTH=5
    logic        b_reset, b_en, b_flush;
    logic [15:0] b_d;
    logic [2:0]  b_sel;
    logic [15:0] b_q;
    logic        b_valid;
    logic [2:0]  b_fill_cnt;
`ifdef SHIFTREG_TAP_ROTATE_EN
    logic        b_rot;
`endif

    shiftreg_tap #(.WIDTH(8), .DEPTH(3)) u_dut_a (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .flush    (flush),
`ifdef SHIFTREG_TAP_ROTATE_EN
        .rot      (rot),
`endif
        .d        (d),
        .sel      (sel),
        .q        (q),
        .valid    (valid),
        .fill_cnt (fill_cnt)
    );

    shiftreg_tap #(.WIDTH(16), .DEPTH(5)) u_dut_b (
        .clk      (clk),
        .reset    (b_reset),
        .en       (b_en),
        .flush    (b_flush),
`ifdef SHIFTREG_TAP_ROTATE_EN
        .rot      (b_rot),
`endif
        .d        (b_d),
        .sel      (b_sel),
        .q        (b_q),
        .valid    (b_valid),
        .fill_cnt (b_fill_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        logic       fl;
        logic [7:0] d;
        logic [1:0] sel;
        logic [7:0] eq;
        logic       ev;
        logic [1:0] ef;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    initial begin
        // rst en fl d sel | q valid fill  (outputs observed just after the edge, inputs held)
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h11, 2'd0, 8'h11, 1'b1, 2'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h22, 2'd2, 8'h00, 1'b0, 2'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h01, 2'd3, 8'h00, 1'b0, 2'd1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h02, 2'd3, 8'h00, 1'b0, 2'd2};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h03, 2'd3, 8'h01, 1'b1, 2'd3};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h04, 2'd3, 8'h02, 1'b1, 2'd3};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'h55, 2'd1, 8'h04, 1'b1, 2'd3};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h55, 2'd2, 8'h03, 1'b1, 2'd3};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'hAA, 2'd1, 8'h00, 1'b0, 2'd0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'hAA, 2'd2, 8'h00, 1'b0, 2'd0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 8'hAA, 2'd3, 8'h00, 1'b0, 2'd0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 8'h05, 2'd1, 8'h05, 1'b1, 2'd1};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 8'h06, 2'd2, 8'h05, 1'b1, 2'd2};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 8'h07, 2'd3, 8'h05, 1'b1, 2'd3};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 8'h09, 2'd0, 8'h09, 1'b1, 2'd3};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 8'h09, 2'd1, 8'h07, 1'b1, 2'd3};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 8'h09, 2'd2, 8'h06, 1'b1, 2'd3};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 8'h09, 2'd3, 8'h05, 1'b1, 2'd3};
        vecs[18] = '{1'b1, 1'b1, 1'b0, 8'h33, 2'd1, 8'h00, 1'b0, 2'd0};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 8'h44, 2'd1, 8'h44, 1'b1, 2'd1};
        vecs[20] = '{1'b0, 1'b1, 1'b0, 8'h45, 2'd3, 8'h00, 1'b0, 2'd2};
        vecs[21] = '{1'b0, 1'b1, 1'b0, 8'h46, 2'd3, 8'h44, 1'b1, 2'd3};
        vecs[22] = '{1'b0, 1'b1, 1'b0, 8'h47, 2'd3, 8'h45, 1'b1, 2'd3};
        vecs[23] = '{1'b1, 1'b1, 1'b1, 8'h12, 2'd0, 8'h12, 1'b1, 2'd0};
    end

    initial begin
        int cnt;
        logic [15:0] exp_q;
        reset = 1'b1; en = 1'b0; flush = 1'b0; d = '0; sel = '0;
        b_reset = 1'b1; b_en = 1'b0; b_flush = 1'b0; b_d = '0; b_sel = '0;
`ifdef SHIFTREG_TAP_ROTATE_EN
        rot = 1'b0; b_rot = 1'b0;
`endif
        #1;

        for (int i = 0; i < NV; i++) begin
            reset = vecs[i].rst; en = vecs[i].en; flush = vecs[i].fl;
            d = vecs[i].d; sel = vecs[i].sel;
            @(posedge clk); #1;
            check($sformatf("v%0d_q", i), 32'(q), 32'(vecs[i].eq));
            check($sformatf("v%0d_valid", i), 32'(valid), 32'(vecs[i].ev));
            check($sformatf("v%0d_fill", i), 32'(fill_cnt), 32'(vecs[i].ef));
        end

        // Wide/deep instance: out-of-range taps read zero, sel=5 needs five enabled clocks.
        b_reset = 1'b1;
        @(posedge clk); #1;
        b_reset = 1'b0; b_sel = 3'd6; b_d = 16'h1234;
        @(posedge clk); #1;
        check("b_sel6_q", 32'(b_q), 32'h0);
        check("b_sel6_valid", 32'(b_valid), 32'h0);
        b_sel = 3'd0;
        #1;
        check("b_bypass_q", 32'(b_q), 32'h1234);

        b_sel = 3'd5;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            // enable pattern 1,0,1,1,0,0,1,1 -> fifth enabled clock is the last one
            b_en = (i == 1 || i == 4 || i == 5) ? 1'b0 : 1'b1;
            b_d  = (i == 0) ? 16'hBEEF : 16'h1000 + 16'(i);
            @(posedge clk); #1;
            if (b_en) cnt++;
            exp_q = (cnt >= 5) ? 16'hBEEF : 16'h0000;
            check($sformatf("b_lat%0d_q", i), 32'(b_q), 32'(exp_q));
            check($sformatf("b_lat%0d_valid", i), 32'(b_valid), (cnt >= 5) ? 32'h1 : 32'h0);
            check($sformatf("b_lat%0d_fill", i), 32'(b_fill_cnt), 32'(cnt));
        end
        b_en = 1'b0; b_sel = 3'd6;
        #1;
        check("b_full_sel6_q", 32'(b_q), 32'h0);
        check("b_full_sel6_valid", 32'(b_valid), 32'h0);
        b_sel = 3'd7;
        #1;
        check("b_full_sel7_q", 32'(b_q), 32'h0);

`ifdef SHIFTREG_TAP_ROTATE_EN
        // Load s1=1,s2=2,s3=3 then rotate three times.
        reset = 1'b1; en = 1'b0; flush = 1'b0; rot = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; en = 1'b1;
        d = 8'h03; @(posedge clk); #1;
        d = 8'h02; @(posedge clk); #1;
        d = 8'h01; @(posedge clk); #1;
        rot = 1'b1; d = 8'hEE;
        @(posedge clk); #1;
        sel = 2'd1; #1; check("rot1_s1", 32'(q), 32'h3);
        sel = 2'd2; #1; check("rot1_s2", 32'(q), 32'h1);
        sel = 2'd3; #1; check("rot1_s3", 32'(q), 32'h2);
        en = 1'b0;
        @(posedge clk); #1;
        check("rot_en0_hold", 32'(q), 32'h2);
        en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rot = 1'b0; en = 1'b0;
        sel = 2'd1; #1; check("rot3_s1", 32'(q), 32'h1);
        sel = 2'd2; #1; check("rot3_s2", 32'(q), 32'h2);
        sel = 2'd3; #1; check("rot3_s3", 32'(q), 32'h3);
        check("rot3_fill", 32'(fill_cnt), 32'h3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shiftreg_tap.md
SHIFTREG_TAP -- requirements
Module: shiftreg_tap

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data width in bits, minimum 1.
REQ-002 The block SHALL have parameter DEPTH, default 3: number of register stages, minimum 1.
REQ-003 The block SHALL have derived localparam SELW = clog2(DEPTH+1): tap-select width, not user-set.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port en, input, 1 bit: shift enable.
REQ-007 The block SHALL have port flush, input, 1 bit: synchronous clear of stages and fill count.
REQ-008 The block SHALL have port d, input, WIDTH bits: serial-in data word.
REQ-009 The block SHALL have port sel, input, SELW bits: output tap select.
REQ-010 The block SHALL have port q, output, WIDTH bits: selected tap data.
REQ-011 The block SHALL have port valid, output, 1 bit: selected tap holds a word shifted in since the last reset or flush.
REQ-012 The block SHALL have port fill_cnt, output, SELW bits: words shifted in since the last reset or flush, saturating at DEPTH.

Function
REQ-013 The block SHALL contain stages s[1]..s[DEPTH], each WIDTH bits.
REQ-014 On a clk edge with en=1 and flush=0, the block SHALL load s[1] from d and s[k] from s[k-1] for k=2..DEPTH.
REQ-015 With en=0 and flush=0, all stages and fill_cnt SHALL hold.
REQ-016 q SHALL be combinational from sel:
  - sel=0: q=d (zero-latency bypass).
  - sel=k, 1<=k<=DEPTH: q=s[k] (latency k enabled clocks).
  - sel>DEPTH: q=0.
REQ-017 fill_cnt SHALL increment by 1 on each enabled shift and saturate at DEPTH, never wrapping.
REQ-018 valid SHALL be combinational:
  - 1 when sel=0.
  - 1 when 1<=sel<=DEPTH and fill_cnt>=sel.
  - 0 otherwise.
REQ-019 flush=1 SHALL clear all stages and fill_cnt to 0 on that edge, take priority over en, and discard the d presented on that edge.
REQ-020 A change of sel SHALL NOT alter any stored state.
REQ-021 Simultaneous en=1 and fill_cnt=DEPTH SHALL shift normally, drop the old s[DEPTH] and keep fill_cnt at DEPTH.

Reset
REQ-022 reset=1 at a clk edge SHALL clear every stage and fill_cnt to 0, overriding en, flush and the ROTATE_EN rot input.
REQ-023 After reset, q SHALL be d when sel=0 and 0 otherwise, and valid SHALL be 1 only when sel=0.
REQ-024 Reset asserted mid-stream SHALL discard all stored data on that edge, and the first enabled shift afterward SHALL give fill_cnt=1.

Configuration
REQ-025 Macro SHIFTREG_TAP_ROTATE_EN defined SHALL add input port rot (1 bit).
REQ-026 With the macro defined, an edge with en=1, rot=1, flush=0 and reset=0 SHALL load s[1] from s[DEPTH] instead of d, shift the other stages as in REQ-014, and leave fill_cnt unchanged.
REQ-027 With the macro defined, rot=1 with en=0 SHALL have no effect.
REQ-028 With the macro undefined, the rot port SHALL NOT exist and behaviour SHALL be exactly REQ-013..REQ-024.

Verification
REQ-029 Reset, then en=1, d=1,2,3,4 on successive clocks, sel=3 -> q=1 and valid=1 after the 3rd shift; q=2 and fill_cnt=3 after the 4th.
REQ-030 Sweep sel 0..3 with stages holding 5,6,7 (s[1]=7) and d=9 -> q=9,7,6,5 for sel=0,1,2,3, valid=1 for all four.
REQ-031 After 2 shifts, sel=3 -> valid=0; one more shift -> valid=1; further shifts -> fill_cnt stays 3.
REQ-032 en=1 and flush=1 on the same edge with d=0xAA -> all stages 0, fill_cnt=0, and 0xAA appears at no tap.
REQ-033 With WIDTH=16, DEPTH=5 and sel=6 -> q=0, valid=0; with sel=5 -> d appears after 5 enabled clocks, with en gaps not counted.
REQ-034 With SHIFTREG_TAP_ROTATE_EN defined and stages holding 1,2,3, en=1, rot=1 for 3 clocks -> stages return to 1,2,3 and fill_cnt is unchanged.
